// File: rtl/uart_rx_oversample_if.sv
// Serial-side and byte-side signals of the oversampling UART receiver.
// The master drives the line and tick source; the receiver (slave) drives the byte outputs.
interface uart_rx_oversample_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_clk;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output baud_clk,
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  baud_clk,
        input  rx,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver on the system clock, using rising edges of the divider square wave
// as oversampling ticks; emits a byte with a valid strobe or a framing-error strobe.
module uart_rx_oversample #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input logic                 i_clk,
    input logic                 i_rst,
    uart_rx_oversample_if.slave io_uart
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE + 1);
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2);
    localparam logic [CntW-1:0] CntFull = CntW'(OVERSAMPLE);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    logic                 r_baud_d;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    state_e               r_state;
    logic [CntW-1:0]      r_cnt;
    logic [BitW-1:0]      r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_err;
    logic                 r_busy;

    logic                 w_tick;
    logic [CntW-1:0]      w_cnt_inc;

    assign w_tick    = io_uart.baud_clk & ~r_baud_d;
    assign w_cnt_inc = r_cnt + CntW'(1);

    // Synchroniser resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_baud_d  <= 1'b0;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_baud_d  <= io_uart.baud_clk;
            r_rx_meta <= io_uart.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    StIdle: begin
                        if (!r_rx_s) begin
                            r_state <= StStart;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (w_cnt_inc == CntHalf) begin
                            r_cnt <= '0;
                            r_bit <= '0;
                            if (!r_rx_s) begin
                                r_state <= StData;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    StData: begin
                        if (w_cnt_inc == CntFull) begin
                            r_cnt <= '0;
                            // Right shift: the first (LSB) bit ends up in bit 0 after DATA_BITS.
                            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            if (r_bit == BitLast) begin
                                r_state <= StStop;
                                r_bit   <= '0;
                            end else begin
                                r_bit <= r_bit + BitW'(1);
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    StStop: begin
                        if (w_cnt_inc == CntFull) begin
                            r_cnt <= '0;
                            if (r_rx_s) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= StWaitIdle;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    StWaitIdle: begin
                        if (r_rx_s) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_uart.data_out   = r_data;
    assign io_uart.data_valid = r_valid;
    assign io_uart.frame_err  = r_err;
    assign io_uart.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed and randomized frames against a frame-level model: expected bytes, error strobes
// and strobe cycles are computed from the tick schedule with plain arithmetic.
module tb_uart_rx_oversample;

    localparam int OS      = 16;
    localparam int BIT_CLK = 64;
    // Stop-bit sample lies OS/2 + 9*OS ticks after detection, 4 clk per tick.
    localparam int STOP_OFS = (OS / 2 + 9 * OS) * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic b_prev = 1'b0;
    int   cyc = 0;
    int   last_tick = 0;
    int   checks = 0;
    int   failures = 0;
    int   both_high = 0;

    int         v_cyc[$];
    logic [7:0] v_dat[$];
    int         e_cyc[$];

    int         f0, f1, low_busy_drops, gap;
    logic [7:0] model_data, rnd_byte;
    logic       rnd_stop;
    logic [9:0] fr;

    uart_rx_oversample_if #(.DATA_BITS(8)) bus_if ();

    uart_rx_oversample #(
        .OVERSAMPLE(OS),
        .DATA_BITS (8)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_uart(bus_if)
    );

    initial forever #5 clk = ~clk;

    initial begin
        bus_if.baud_clk = 1'b0;
        #10;
        forever begin
            bus_if.baud_clk = 1'b1;
            #20;
            bus_if.baud_clk = 1'b0;
            #20;
        end
    end

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        b_prev <= bus_if.baud_clk;
        if (bus_if.baud_clk && !b_prev) last_tick <= cyc + 1;
    end

    always @(negedge clk) begin
        if (bus_if.data_valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(bus_if.data_out);
        end
        if (bus_if.frame_err) e_cyc.push_back(cyc);
        if (bus_if.data_valid && bus_if.frame_err) both_high++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // First tick on which the synchronised line can show the fall made at cycle f.
    function automatic int detect_cyc(input int f);
        int d = f + 3;
        while (((d - last_tick) % 4) != 0) d++;
        return d;
    endfunction

    task automatic clear_q();
        v_cyc.delete();
        v_dat.delete();
        e_cyc.delete();
    endtask

    task automatic idle(input int n);
        bus_if.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int fall);
        fall = cyc;
        bus_if.rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus_if.rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        bus_if.rx = stop;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    initial begin
        bus_if.rx = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_data_out", 32'(bus_if.data_out), 32'h00);
        chk("rst_busy", 32'(bus_if.busy), 32'h0);
        rst = 1'b0;

        // 1: idle line
        idle(500);
        #1;
        chk("idle_valid_cnt", 32'(v_cyc.size()), 32'd0);
        chk("idle_err_cnt", 32'(e_cyc.size()), 32'd0);
        chk("idle_busy", 32'(bus_if.busy), 32'h0);
        chk("idle_data_out", 32'(bus_if.data_out), 32'h00);
        clear_q();
        @(negedge clk);

        // 2: single frame 0xA5
        send_frame(8'hA5, 1'b1, f0);
        idle(2 * BIT_CLK);
        #1;
        chk("a5_valid_cnt", 32'(v_cyc.size()), 32'd1);
        chk("a5_data", 32'((v_dat.size() > 0) ? v_dat[0] : 8'hxx), 32'hA5);
        chk("a5_cycle", 32'((v_cyc.size() > 0) ? v_cyc[0] : -1), 32'(detect_cyc(f0) + STOP_OFS));
        chk("a5_err_cnt", 32'(e_cyc.size()), 32'd0);
        chk("a5_data_out", 32'(bus_if.data_out), 32'hA5);
        clear_q();
        @(negedge clk);

        // 3: back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1, f0);
        send_frame(8'hFF, 1'b1, f1);
        idle(BIT_CLK);
        #1;
        chk("b2b_valid_cnt", 32'(v_cyc.size()), 32'd2);
        chk("b2b_first", 32'((v_dat.size() > 0) ? v_dat[0] : 8'hxx), 32'h00);
        chk("b2b_second", 32'((v_dat.size() > 1) ? v_dat[1] : 8'hxx), 32'hFF);
        chk("b2b_spacing_ok", 32'((v_cyc.size() > 1) &&
            (v_cyc[1] - v_cyc[0] >= 636) && (v_cyc[1] - v_cyc[0] <= 644)), 32'd1);
        chk("b2b_second_cycle", 32'((v_cyc.size() > 1) ? v_cyc[1] : -1),
            32'(detect_cyc(f1) + STOP_OFS));
        clear_q();
        @(negedge clk);

        // 4: framing error, break, recovery
        send_frame(8'h3C, 1'b0, f0);
        low_busy_drops = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!bus_if.busy) low_busy_drops++;
        end
        chk("brk_busy_drops", 32'(low_busy_drops), 32'd0);
        chk("brk_err_cnt", 32'(e_cyc.size()), 32'd1);
        chk("brk_err_cycle", 32'((e_cyc.size() > 0) ? e_cyc[0] : -1),
            32'(detect_cyc(f0) + STOP_OFS));
        chk("brk_valid_cnt", 32'(v_cyc.size()), 32'd0);
        chk("brk_data_kept", 32'(bus_if.data_out), 32'hFF);
        @(negedge clk);
        idle(BIT_CLK);
        #1;
        chk("brk_busy_after_high", 32'(bus_if.busy), 32'h0);
        clear_q();
        @(negedge clk);
        send_frame(8'h81, 1'b1, f0);
        idle(BIT_CLK);
        #1;
        chk("rec_valid_cnt", 32'(v_cyc.size()), 32'd1);
        chk("rec_data", 32'(bus_if.data_out), 32'h81);
        chk("rec_err_cnt", 32'(e_cyc.size()), 32'd0);
        clear_q();
        @(negedge clk);

        // 5: 20-clk glitch
        bus_if.rx = 1'b0;
        repeat (20) @(negedge clk);
        bus_if.rx = 1'b1;
        #1;
        chk("glitch_busy_during", 32'(bus_if.busy), 32'h1);
        repeat (40) @(negedge clk);
        #1;
        chk("glitch_busy_after", 32'(bus_if.busy), 32'h0);
        idle(200);
        #1;
        chk("glitch_valid_cnt", 32'(v_cyc.size()), 32'd0);
        chk("glitch_err_cnt", 32'(e_cyc.size()), 32'd0);
        clear_q();
        @(negedge clk);

        // 6: reset in the middle of data bit 4 of 0x5A
        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus_if.rx = fr[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        bus_if.rx = fr[5];
        repeat (BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_data_out", 32'(bus_if.data_out), 32'h00);
        chk("mid_rst_valid", 32'(bus_if.data_valid), 32'h0);
        chk("mid_rst_err", 32'(bus_if.frame_err), 32'h0);
        chk("mid_rst_busy", 32'(bus_if.busy), 32'h0);
        rst = 1'b0;
        idle(700);
        #1;
        chk("mid_rst_valid_cnt", 32'(v_cyc.size()), 32'd0);
        chk("mid_rst_err_cnt", 32'(e_cyc.size()), 32'd0);
        clear_q();
        @(negedge clk);
        send_frame(8'h5A, 1'b1, f0);
        idle(BIT_CLK);
        #1;
        chk("post_rst_valid_cnt", 32'(v_cyc.size()), 32'd1);
        chk("post_rst_data", 32'(bus_if.data_out), 32'h5A);
        chk("post_rst_cycle", 32'((v_cyc.size() > 0) ? v_cyc[0] : -1),
            32'(detect_cyc(f0) + STOP_OFS));
        clear_q();
        @(negedge clk);

        // 7: random frames, some with a bad stop bit
        model_data = 8'h5A;
        for (int n = 0; n < 12; n++) begin
            rnd_byte = 8'($urandom_range(0, 255));
            rnd_stop = ($urandom_range(0, 3) != 0);
            gap      = rnd_stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(rnd_byte, rnd_stop, f0);
            #1;
            if (rnd_stop) model_data = rnd_byte;
            chk("rnd_valid_cnt", 32'(v_cyc.size()), 32'(rnd_stop ? 1 : 0));
            chk("rnd_err_cnt", 32'(e_cyc.size()), 32'(rnd_stop ? 0 : 1));
            chk("rnd_data_out", 32'(bus_if.data_out), 32'(model_data));
            chk("rnd_strobe_cycle",
                32'(rnd_stop ? ((v_cyc.size() > 0) ? v_cyc[0] : -1)
                             : ((e_cyc.size() > 0) ? e_cyc[0] : -1)),
                32'(detect_cyc(f0) + STOP_OFS));
            clear_q();
            @(negedge clk);
            idle(gap * BIT_CLK);
        end
        idle(2 * BIT_CLK);
        #1;
        chk("final_busy", 32'(bus_if.busy), 32'h0);
        chk("strobes_exclusive", 32'(both_high), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- 8N1 UART receiver that consumes the UART square wave from the clock divider (`baud_clk`, OVERSAMPLE × baud rate) as a tick source.
- Runs entirely on the 100 MHz system clock; `baud_clk` is never used as a clock.
- Turns the serial `rx` pin into parallel bytes with a one-cycle valid strobe and a framing-error strobe.
- Output feeds the command decoder / game-control logic.

Parameters:
- OVERSAMPLE, 16, ticks per bit; even, ≥4.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  100 MHz system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- baud_clk  input  1  divider square wave, same clock domain; each rising edge is one tick.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  last correctly framed byte; holds until the next good frame.
- data_valid  output  1  one-clk pulse when `data_out` updates.
- frame_err  output  1  one-clk pulse when the stop bit samples 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Tick generation:
  - baud_d register: reset 0, captures `baud_clk` every clk.
  - tick = `baud_clk` & ~baud_d, combinational.
  - The constant-low / constant-high `baud_clk` case produces no ticks; the FSM freezes.
- rx synchroniser:
  - Two flops, both reset to 1; rx_s is the second flop.
  - Reset to 1 prevents a false start after reset.
- Reset values: `data_out` = 0, `data_valid` = 0, `frame_err` = 0, `busy` = 0, state = IDLE, tick counter = 0, bit counter = 0, shift register = 0.
- Reset asserted mid-frame: abandon the frame, no strobes, return to IDLE.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. The counter and all sampling advance only on tick cycles.
  - IDLE: on a tick with rx_s = 0 → START, cnt = 0.
  - START: cnt += 1 per tick. At cnt = OVERSAMPLE/2 (mid start bit), sample rx_s:
    - 0 → DATA, cnt = 0, bit = 0.
    - 1 → glitch; back to IDLE, no strobe.
  - DATA: cnt += 1 per tick. When cnt reaches OVERSAMPLE: sample rx_s into shift bit [bit] (LSB first), cnt = 0, bit += 1. After bit DATA_BITS-1 is sampled → STOP.
  - STOP: when cnt reaches OVERSAMPLE, sample rx_s:
    - 1 → `data_out` <= shift, `data_valid` = 1 on the next clk only, → IDLE.
    - 0 → `frame_err` = 1 on the next clk only, `data_out` unchanged, → WAIT_IDLE.
  - WAIT_IDLE (break/line low): stay until a tick with rx_s = 1, then → IDLE. No strobes in this state.
- Latency:
  - Falling edge of `rx` to detection: ≤ 2 clk (synchroniser) + wait for the next tick.
  - Strobe timing: asserted exactly 1 clk after the tick that samples the stop bit.
  - Sampling points: ticks T0+OVERSAMPLE/2 + k·OVERSAMPLE (T0 = detect tick), k = 0 for start, 1..DATA_BITS for data, DATA_BITS+1 for stop.
- Counter widths: cnt ≥ clog2(OVERSAMPLE+1) bits; bit counter ≥ clog2(DATA_BITS+1) bits. Counters are never allowed to wrap silently.
- `data_valid` and `frame_err` are mutually exclusive and never both high.
- Back-to-back frames: a new start bit is accepted on the first tick in IDLE with rx_s = 0, so zero idle bits between frames is supported.
- `busy` = 1 in START, DATA, STOP, WAIT_IDLE.

Test Plan:
Common bench setup: OVERSAMPLE = 16; `baud_clk` toggles every 2 clk (tick every 4 clk, bit = 64 clk).
1. Reset, `rx` = 1 for 500 clk → no strobes, `busy` = 0, `data_out` = 0x00.
2. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → exactly one `data_valid` pulse, `data_out` = 0xA5. Pulse falls within 1 clk after tick T0+8+9·16; `frame_err` never high.
3. Two back-to-back frames 0x00 then 0xFF, no idle gap → two `data_valid` pulses, values 0x00 then 0xFF, 10 bits (640 clk) apart ± 4 clk.
4. Frame 0x3C with stop bit forced 0, then `rx` held low 300 clk, then high, then frame 0x81:
   - one `frame_err` pulse and `data_out` stays at the prior value;
   - `busy` stays high until `rx` returns high;
   - 0x81 is then received cleanly.
5. Low glitch on `rx` of 20 clk (< half bit) → returns to IDLE, no strobes, `busy` drops within 40 clk after the glitch.
6. Assert `rst` for 1 clk in the middle of data bit 4 of 0x5A → no strobes. All outputs read 0 the cycle after reset. A subsequent clean 0x5A is received correctly.
